// File: rtl/spi_flash_read_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_flash_read_master
// Purpose  : Single-word SPI NOR flash read engine (mode 0, READ 0x03).
//            It accepts one byte-address request and sends the command byte
//            followed by the address, MSB first. It then clocks in 4 bytes
//            and returns them as a little-endian word. The first byte
//            received from the flash lands in rsp_data_o[7:0].
// Ports    : clk_i, rst_ni           - clock, async active-low reset
//            req_valid_i/req_ready_o - request handshake, req_addr_i = byte addr
//            rsp_valid_o/rsp_ready_i - response handshake, rsp_data_o = word
//            busy_o                  - high whenever the engine is not idle
//            spi_cs_n_o, spi_sck_o,
//            spi_mosi_o, spi_miso_i  - SPI flash pins (all outputs from flops)
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_read_master #(
  parameter int unsigned ClkDiv    = 2,
  parameter int unsigned AddrWidth = 24,
  parameter int unsigned DataWidth = 32,
  parameter logic [7:0]  CmdRead   = 8'h03
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 busy_o,
  output logic                 spi_cs_n_o,
  output logic                 spi_sck_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i
);

  localparam int unsigned TxWidth   = 8 + AddrWidth;
  localparam int unsigned FrameBits = TxWidth + DataWidth;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = $clog2(ClkDiv + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] RxFirst = BitW'(TxWidth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [TxWidth-1:0]     tx_q, tx_d;
  logic [DataWidth-1:0]   rx_q, rx_d;
  logic                   cs_n_q, cs_n_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0]   rsp_data_q, rsp_data_d;
  logic [DataWidth-1:0]   rx_swapped;

  // The flash sends its bytes MSB first, so the first byte ends up at the top
  // of the receive shifter. Reverse the byte order to get a little-endian word.
  always_comb begin
    rx_swapped = '0;
    for (int i = 0; i < DataWidth / 8; i++) begin
      rx_swapped[8*i +: 8] = rx_q[DataWidth-1-8*i -: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          tx_d    = {CmdRead, req_addr_i};
          mosi_d  = CmdRead[7];
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sck_q) begin
            // End of the low phase: raise SCK and capture MISO on this same edge.
            sck_d = 1'b1;
            if (bit_q >= RxFirst) begin
              rx_d = {rx_q[DataWidth-2:0], spi_miso_i};
            end
          end else begin
            sck_d = 1'b0;
            if (bit_q == BitLast) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              // tx_q[TxWidth-1] is the bit on the wire now. The left shift
              // fills with zeros, so MOSI is low during the data phase.
              bit_d  = bit_q + 1'b1;
              tx_d   = tx_q << 1;
              mosi_d = tx_q[TxWidth-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      HOLD: begin
        if (div_q == DivLast) begin
          div_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_swapped;
          state_d     = RESP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign spi_cs_n_o  = cs_n_q;
  assign spi_sck_o   = sck_q;
  assign spi_mosi_o  = mosi_q;

endmodule
`default_nettype wire
